// File: rtl/multicycle_conunit.sv
// Multi-cycle MIPS control unit: steps each instruction through
// IF/ID/EX/MEM/WB over one shared memory port (MemReq/MemRdy handshake)
// and drives the same datapath control encodings as the single-cycle unit.
// A memory request left unanswered for MEM_TIMEOUT cycles raises a sticky
// Fault and parks the unit in HALT until rst_n is asserted.
module multicycle_conunit #(
  parameter int ALUC_W      = 4,
  parameter int PCSRC_W     = 2,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         Op,
  input  logic [5:0]         Func,
  input  logic               Zero,
  input  logic               Sign,
  input  logic               MemRdy,
  output logic               MemReq,
  output logic               memWr,
  output logic               PcWr,
  output logic               IrWr,
  output logic [ALUC_W-1:0]  Aluc,
  output logic               AluSrcA,
  output logic               AluSrcB,
  output logic [PCSRC_W-1:0] PcSrc,
  output logic               Wrback,
  output logic               RegDst,
  output logic               ExtSe,
  output logic               regWr,
  output logic               InstrDone,
  output logic               IllegalOp,
  output logic               Fault
);

  // ALU operation codes
  localparam logic [ALUC_W-1:0] ALU_ADD  = ALUC_W'(4'd0);
  localparam logic [ALUC_W-1:0] ALU_SUB  = ALUC_W'(4'd1);
  localparam logic [ALUC_W-1:0] ALU_AND  = ALUC_W'(4'd2);
  localparam logic [ALUC_W-1:0] ALU_OR   = ALUC_W'(4'd3);
  localparam logic [ALUC_W-1:0] ALU_XOR  = ALUC_W'(4'd4);
  localparam logic [ALUC_W-1:0] ALU_NOR  = ALUC_W'(4'd5);
  localparam logic [ALUC_W-1:0] ALU_SLT  = ALUC_W'(4'd6);
  localparam logic [ALUC_W-1:0] ALU_SLTU = ALUC_W'(4'd7);
  localparam logic [ALUC_W-1:0] ALU_SLL  = ALUC_W'(4'd8);
  localparam logic [ALUC_W-1:0] ALU_SRL  = ALUC_W'(4'd9);
  localparam logic [ALUC_W-1:0] ALU_SRA  = ALUC_W'(4'd10);

  // Datapath mux encodings
  localparam logic [PCSRC_W-1:0] PC_NEXT   = PCSRC_W'(2'd0);
  localparam logic [PCSRC_W-1:0] PC_BRANCH = PCSRC_W'(2'd1);
  localparam logic [PCSRC_W-1:0] PC_JUMP   = PCSRC_W'(2'd2);
  localparam logic FROM_DATA = 1'b0;  // AluSrcA / AluSrcB register operand
  localparam logic FROM_SA   = 1'b1;  // AluSrcA shift amount
  localparam logic FROM_IMMD = 1'b1;  // AluSrcB immediate
  localparam logic FROM_ALU  = 1'b0;
  localparam logic FROM_DM   = 1'b1;
  localparam logic FROM_RT   = 1'b0;
  localparam logic FROM_RD   = 1'b1;
  localparam logic ZERO_EXD  = 1'b0;
  localparam logic SIGN_EXD  = 1'b1;

  // Opcodes. BGEZ/BLTZ share REGIMM in MIPS and are split by rt, which
  // this unit never sees, so BLTZ is given a spare opcode of its own.
  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_BGEZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010, OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100, OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110, OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000, OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010, OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100, OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110, OP_BLTZ  = 6'b011000;
  localparam logic [5:0] OP_LB    = 6'b100000, OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SB    = 6'b101000, OP_SW    = 6'b101011;

  // R-type funct codes
  localparam logic [5:0] F_SLL  = 6'b000000, F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011, F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110, F_SRAV = 6'b000111;
  localparam logic [5:0] F_JR   = 6'b001000, F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001, F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011, F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101, F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111, F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    K_ALU_R, K_ALU_I, K_LOAD, K_STORE, K_BRANCH, K_JUMP, K_ILLEGAL
  } kind_t;

  typedef struct packed {
    logic [ALUC_W-1:0] aluc;
    logic              src_a;
    logic              src_b;
    logic              ext;
  } ex_t;

  // Instruction class, used to pick the state after ID and EX.
  function automatic kind_t classify(input logic [5:0] op, input logic [5:0] func);
    kind_t k;
    k = K_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (func)
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV: k = K_ALU_R;
          F_JR:    k = K_JUMP;
          default: k = K_ILLEGAL;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI:                            k = K_ALU_I;
      OP_LW, OP_LB:                                        k = K_LOAD;
      OP_SW, OP_SB:                                        k = K_STORE;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BGEZ, OP_BLTZ:  k = K_BRANCH;
      OP_J, OP_JAL:                                        k = K_JUMP;
      default:                                             k = K_ILLEGAL;
    endcase
    return k;
  endfunction

  // Single-cycle decode table for the EX-stage ALU controls.
  function automatic ex_t ex_decode(input logic [5:0] op, input logic [5:0] func);
    ex_t d;
    d.aluc  = ALU_ADD;
    d.src_a = FROM_DATA;
    d.src_b = FROM_DATA;
    d.ext   = SIGN_EXD;
    case (op)
      OP_RTYPE: begin
        case (func)
          F_SUB, F_SUBU: d.aluc = ALU_SUB;
          F_AND:         d.aluc = ALU_AND;
          F_OR:          d.aluc = ALU_OR;
          F_XOR:         d.aluc = ALU_XOR;
          F_NOR:         d.aluc = ALU_NOR;
          F_SLT:         d.aluc = ALU_SLT;
          F_SLTU:        d.aluc = ALU_SLTU;
          F_SLL:         begin d.aluc = ALU_SLL; d.src_a = FROM_SA; end
          F_SRL:         begin d.aluc = ALU_SRL; d.src_a = FROM_SA; end
          F_SRA:         begin d.aluc = ALU_SRA; d.src_a = FROM_SA; end
          F_SLLV:        d.aluc = ALU_SLL;
          F_SRLV:        d.aluc = ALU_SRL;
          F_SRAV:        d.aluc = ALU_SRA;
          default:       d.aluc = ALU_ADD;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_LB, OP_SW, OP_SB: d.src_b = FROM_IMMD;
      OP_SLTI:  begin d.aluc = ALU_SLT;  d.src_b = FROM_IMMD; end
      OP_SLTIU: begin d.aluc = ALU_SLTU; d.src_b = FROM_IMMD; end
      OP_ANDI:  begin d.aluc = ALU_AND;  d.src_b = FROM_IMMD; d.ext = ZERO_EXD; end
      OP_ORI:   begin d.aluc = ALU_OR;   d.src_b = FROM_IMMD; d.ext = ZERO_EXD; end
      OP_XORI:  begin d.aluc = ALU_XOR;  d.src_b = FROM_IMMD; d.ext = ZERO_EXD; end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BGEZ, OP_BLTZ: d.aluc = ALU_SUB;
      default:  d.aluc = ALU_ADD;
    endcase
    return d;
  endfunction

  // Branch condition from the ALU flags of rs - rt (or rs - 0).
  function automatic logic branch_taken(input logic [5:0] op, input logic zero, input logic sign);
    logic t;
    case (op)
      OP_BEQ:  t = zero;
      OP_BNE:  t = !zero;
      OP_BGTZ: t = !sign && !zero;
      OP_BGEZ: t = !sign;
      OP_BLTZ: t = sign;
      OP_BLEZ: t = sign || zero;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  state_t          state_r, state_s;
  logic [5:0]      op_r, func_r;
  logic [TO_W-1:0] to_cnt_r;
  logic            fault_r;
  kind_t           kind_ex_s;
  ex_t             ex_s;

  assign kind_ex_s = classify(op_r, func_r);
  assign ex_s      = ex_decode(op_r, func_r);
  assign Fault     = fault_r;

  // State register, latched instruction fields, timeout counter, sticky fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      op_r     <= 6'd0;
      func_r   <= 6'd0;
      to_cnt_r <= '0;
      fault_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_r == S_ID) begin
        op_r   <= Op;
        func_r <= Func;
      end else begin
        op_r   <= op_r;
        func_r <= func_r;
      end
      if ((state_r == S_IF || state_r == S_MEM) && !MemRdy) begin
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end else begin
        to_cnt_r <= '0;
      end
      if (state_s == S_HALT) begin
        fault_r <= 1'b1;
      end else begin
        fault_r <= fault_r;
      end
    end
  end

  // Next-state selection and per-state datapath controls.
  always_comb begin
    state_s   = state_r;
    MemReq    = 1'b0;
    memWr     = 1'b0;
    PcWr      = 1'b0;
    IrWr      = 1'b0;
    regWr     = 1'b0;
    InstrDone = 1'b0;
    IllegalOp = 1'b0;
    Aluc      = ALU_ADD;
    AluSrcA   = FROM_DATA;
    AluSrcB   = FROM_DATA;
    PcSrc     = PC_NEXT;
    Wrback    = FROM_ALU;
    RegDst    = FROM_RD;
    ExtSe     = SIGN_EXD;
    case (state_r)
      S_IDLE: state_s = S_IF;
      S_IF: begin
        MemReq = 1'b1;
        if (MemRdy) begin
          IrWr    = 1'b1;
          PcWr    = 1'b1;
          state_s = S_ID;
        end else if (to_cnt_r == TO_LIMIT) begin
          state_s = S_HALT;
        end else begin
          state_s = S_IF;
        end
      end
      S_ID: begin
        if (classify(Op, Func) == K_ILLEGAL) begin
          IllegalOp = 1'b1;
          InstrDone = 1'b1;
          state_s   = S_IF;
        end else begin
          state_s   = S_EX;
        end
      end
      S_EX: begin
        Aluc    = ex_s.aluc;
        AluSrcA = ex_s.src_a;
        AluSrcB = ex_s.src_b;
        ExtSe   = ex_s.ext;
        case (kind_ex_s)
          K_BRANCH: begin
            if (branch_taken(op_r, Zero, Sign)) begin
              PcWr  = 1'b1;
              PcSrc = PC_BRANCH;
            end else begin
              PcWr  = 1'b0;
            end
            InstrDone = 1'b1;
            state_s   = S_IF;
          end
          K_JUMP: begin
            PcWr      = 1'b1;
            PcSrc     = PC_JUMP;
            InstrDone = 1'b1;
            state_s   = S_IF;
          end
          K_LOAD, K_STORE:  state_s = S_MEM;
          K_ALU_R, K_ALU_I: state_s = S_WB;
          default:          state_s = S_IF;
        endcase
      end
      S_MEM: begin
        MemReq = 1'b1;
        memWr  = (kind_ex_s == K_STORE);
        if (MemRdy) begin
          if (kind_ex_s == K_STORE) begin
            InstrDone = 1'b1;
            state_s   = S_IF;
          end else begin
            state_s   = S_WB;
          end
        end else if (to_cnt_r == TO_LIMIT) begin
          state_s = S_HALT;
        end else begin
          state_s = S_MEM;
        end
      end
      S_WB: begin
        regWr     = 1'b1;
        InstrDone = 1'b1;
        state_s   = S_IF;
        if (kind_ex_s == K_LOAD) begin
          Wrback = FROM_DM;
        end else begin
          Wrback = FROM_ALU;
        end
        if (kind_ex_s == K_ALU_R) begin
          RegDst = FROM_RD;
        end else begin
          RegDst = FROM_RT;
        end
      end
      S_HALT:  state_s = S_HALT;
      default: state_s = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_conunit.sv
// Directed bench for multicycle_conunit: walks ALU, load, store, branch,
// jump and illegal instructions cycle by cycle, then the fetch-timeout
// boundary, HALT behaviour and asynchronous reset mid-instruction.
module tb_multicycle_conunit;

  typedef struct packed {
    logic       mem_req, mem_wr, pc_wr, ir_wr, reg_wr, done, ill, fault;
    logic [3:0] aluc;
    logic       srca, srcb;
    logic [1:0] pcsrc;
    logic       wb, rd, ext;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Op, Func;
  logic       Zero, Sign, MemRdy;
  logic       MemReq, memWr, PcWr, IrWr, AluSrcA, AluSrcB, Wrback, RegDst, ExtSe;
  logic       regWr, InstrDone, IllegalOp, Fault;
  logic [3:0] Aluc;
  logic [1:0] PcSrc;
  outs_t      obs, e;
  int         nvec = 0;
  int         nerr = 0;

  always #5 clk = ~clk;

  multicycle_conunit dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Func(Func), .Zero(Zero), .Sign(Sign),
    .MemRdy(MemRdy), .MemReq(MemReq), .memWr(memWr), .PcWr(PcWr), .IrWr(IrWr),
    .Aluc(Aluc), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .PcSrc(PcSrc),
    .Wrback(Wrback), .RegDst(RegDst), .ExtSe(ExtSe), .regWr(regWr),
    .InstrDone(InstrDone), .IllegalOp(IllegalOp), .Fault(Fault)
  );

  assign obs = {MemReq, memWr, PcWr, IrWr, regWr, InstrDone, IllegalOp, Fault,
                Aluc, AluSrcA, AluSrcB, PcSrc, Wrback, RegDst, ExtSe};

  // Idle values: ALUAdd, NextIns, FromData, FromALU, FromRd(1), SignExd(1).
  function automatic outs_t rst_o();
    outs_t o;
    o     = '0;
    o.rd  = 1'b1;
    o.ext = 1'b1;
    return o;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input outs_t exp_o);
    nvec++;
    assert (obs === exp_o) else begin
      nerr++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp_o);
    end
  endtask

  task automatic do_fetch(input string tag, input logic [5:0] op, input logic [5:0] fn);
    outs_t x;
    cyc();
    Op = op; Func = fn; MemRdy = 1'b1;
    #1;
    x = rst_o(); x.mem_req = 1'b1; x.ir_wr = 1'b1; x.pc_wr = 1'b1;
    chk(tag, x);
  endtask

  task automatic do_id(input string tag);
    cyc();
    #1;
    chk(tag, rst_o());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; MemRdy = 1'b0; Op = 6'd0; Func = 6'd0; Zero = 1'b0; Sign = 1'b0;
    #3;
    chk("reset", rst_o());
    cyc(); #1;
    chk("reset_hold", rst_o());
    rst_n = 1'b1;
    #1;
    chk("idle", rst_o());

    // Fetch waits 15 cycles; MemRdy on the 16th beats the timeout.
    for (int i = 0; i < 15; i++) begin
      cyc(); MemRdy = 1'b0; #1;
      e = rst_o(); e.mem_req = 1'b1;
      chk("if_wait", e);
    end
    do_fetch("add.if_boundary", 6'b000000, 6'b100000);
    do_id("add.id");
    cyc(); #1; chk("add.ex", rst_o());
    cyc(); #1;
    e = rst_o(); e.reg_wr = 1'b1; e.done = 1'b1;
    chk("add.wb", e);

    // ORI: ALUOr, immediate, zero-extend, write rt.
    do_fetch("ori.if", 6'b001101, 6'b000000);
    do_id("ori.id");
    cyc(); #1;
    e = rst_o(); e.aluc = 4'd3; e.srcb = 1'b1; e.ext = 1'b0;
    chk("ori.ex", e);
    cyc(); #1;
    e = rst_o(); e.reg_wr = 1'b1; e.done = 1'b1; e.rd = 1'b0;
    chk("ori.wb", e);

    // SLL: ALUSll with shift-amount operand.
    do_fetch("sll.if", 6'b000000, 6'b000000);
    do_id("sll.id");
    cyc(); #1;
    e = rst_o(); e.aluc = 4'd8; e.srca = 1'b1;
    chk("sll.ex", e);
    cyc(); #1;
    e = rst_o(); e.reg_wr = 1'b1; e.done = 1'b1;
    chk("sll.wb", e);

    // LW with three MEM wait cycles: regWr in cycle 8.
    do_fetch("lw.if", 6'b100011, 6'b000000);
    do_id("lw.id");
    cyc(); #1;
    e = rst_o(); e.srcb = 1'b1;
    chk("lw.ex", e);
    for (int i = 0; i < 3; i++) begin
      cyc(); MemRdy = 1'b0; #1;
      e = rst_o(); e.mem_req = 1'b1;
      chk("lw.mem_wait", e);
    end
    cyc(); MemRdy = 1'b1; #1;
    e = rst_o(); e.mem_req = 1'b1;
    chk("lw.mem_rdy", e);
    cyc(); #1;
    e = rst_o(); e.reg_wr = 1'b1; e.done = 1'b1; e.wb = 1'b1; e.rd = 1'b0;
    chk("lw.wb", e);

    // BEQ taken.
    do_fetch("beq_t.if", 6'b000100, 6'b000000);
    do_id("beq_t.id");
    cyc(); Zero = 1'b1; Sign = 1'b0; #1;
    e = rst_o(); e.aluc = 4'd1; e.pc_wr = 1'b1; e.pcsrc = 2'd1; e.done = 1'b1;
    chk("beq_t.ex", e);

    // BEQ not taken.
    do_fetch("beq_n.if", 6'b000100, 6'b000000);
    do_id("beq_n.id");
    cyc(); Zero = 1'b0; Sign = 1'b0; #1;
    e = rst_o(); e.aluc = 4'd1; e.done = 1'b1;
    chk("beq_n.ex", e);

    // BGTZ taken on a positive result.
    do_fetch("bgtz.if", 6'b000111, 6'b000000);
    do_id("bgtz.id");
    cyc(); Zero = 1'b0; Sign = 1'b0; #1;
    e = rst_o(); e.aluc = 4'd1; e.pc_wr = 1'b1; e.pcsrc = 2'd1; e.done = 1'b1;
    chk("bgtz.ex", e);

    // BLEZ not taken on a positive result.
    do_fetch("blez.if", 6'b000110, 6'b000000);
    do_id("blez.id");
    cyc(); Zero = 1'b0; Sign = 1'b0; #1;
    e = rst_o(); e.aluc = 4'd1; e.done = 1'b1;
    chk("blez.ex", e);

    // J.
    do_fetch("j.if", 6'b000010, 6'b000000);
    do_id("j.id");
    cyc(); #1;
    e = rst_o(); e.pc_wr = 1'b1; e.pcsrc = 2'd2; e.done = 1'b1;
    chk("j.ex", e);

    // SW completes in MEM.
    do_fetch("sw.if", 6'b101011, 6'b000000);
    do_id("sw.id");
    cyc(); #1;
    e = rst_o(); e.srcb = 1'b1;
    chk("sw.ex", e);
    cyc(); #1;
    e = rst_o(); e.mem_req = 1'b1; e.mem_wr = 1'b1; e.done = 1'b1;
    chk("sw.mem", e);

    // Illegal opcode, then fetch starves into HALT after 16 request cycles.
    do_fetch("ill.if", 6'b111111, 6'b000000);
    cyc(); #1;
    e = rst_o(); e.ill = 1'b1; e.done = 1'b1;
    chk("ill.id", e);
    for (int i = 0; i < 16; i++) begin
      cyc(); MemRdy = 1'b0; #1;
      e = rst_o(); e.mem_req = 1'b1;
      chk("to.if_wait", e);
    end
    cyc(); #1;
    e = rst_o(); e.fault = 1'b1;
    chk("to.halt", e);
    MemRdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("to.halt_sticky", e);
    end
    rst_n = 1'b0;
    #1;
    chk("to.reset_clears", rst_o());
    cyc(); rst_n = 1'b1; #1;
    chk("to.idle", rst_o());

    // Asynchronous reset in the middle of a store's MEM wait.
    do_fetch("swr.if", 6'b101011, 6'b000000);
    do_id("swr.id");
    cyc(); #1;
    e = rst_o(); e.srcb = 1'b1;
    chk("swr.ex", e);
    cyc(); MemRdy = 1'b0; #1;
    e = rst_o(); e.mem_req = 1'b1; e.mem_wr = 1'b1;
    chk("swr.mem_wait", e);
    rst_n = 1'b0;
    #1;
    chk("swr.async_reset", rst_o());
    cyc(); rst_n = 1'b1; #1;
    chk("swr.idle", rst_o());
    cyc(); #1;
    e = rst_o(); e.mem_req = 1'b1;
    chk("swr.if", e);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/multicycle_conunit.md
Name: multicycle_conunit

Overview:
Multi-cycle successor to the single-cycle control unit. It sequences each MIPS instruction through IF/ID/EX/MEM/WB states over a shared memory port with a req/ready handshake. It generates per-state datapath enables with the same encodings as the single-cycle control (`define.v` macros), and sits between the instruction register, the ALU flags and the datapath muxes.

Parameters:
ALUC_W, 4, width of Aluc (`ALU*` codes)
PCSRC_W, 2, width of PcSrc (`NextIns`/`Branch`/`Jump`)
MEM_TIMEOUT, 16, max cycles MemReq may wait for MemRdy before Fault (>=1)
TO_W, 5, timeout counter width (>= clog2(MEM_TIMEOUT+1))

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
Op  in  6  opcode from instruction register (valid from ID)
Func  in  6  funct field (valid from ID)
Zero  in  1  ALU zero flag (valid in EX)
Sign  in  1  ALU sign flag (valid in EX)
MemRdy  in  1  memory completes current request this cycle
MemReq  out  1  memory request (IF fetch or MEM access)
memWr  out  1  store qualifier for MemReq
PcWr  out  1  PC register load
IrWr  out  1  instruction register load
Aluc  out  ALUC_W  ALU operation
AluSrcA  out  1  `FromSA`/`FromData`
AluSrcB  out  1  `FromImmd`/`FromData`
PcSrc  out  PCSRC_W  next-PC select
Wrback  out  1  `FromDM`/`FromALU`
RegDst  out  1  `FromRt`/`FromRd`
ExtSe  out  1  `ZeroExd`/`SignExd`
regWr  out  1  register-file write enable (WB only)
InstrDone  out  1  one-cycle pulse on the last cycle of each instruction
IllegalOp  out  1  one-cycle pulse in ID for an undecoded Op/Func
Fault  out  1  sticky memory-timeout flag

Behaviour:
- Reset (async, rst_n=0): state=IDLE, timeout counter=0, Fault=0, latched Op/Func=0. All outputs 0, except Aluc=`ALUAdd`, PcSrc=`NextIns`, AluSrcA=`FromData`, AluSrcB=`FromData`, Wrback=`FromALU`, RegDst=`FromRd`, ExtSe=`SignExd`. Reset mid-instruction aborts with no further writes.
- IDLE -> IF unconditionally on the first clock after reset release.
- IF: MemReq=1, memWr=0. When MemRdy=1, assert IrWr=1 and PcWr=1 (PcSrc=`NextIns`) in that cycle, then go to ID. Otherwise stay in IF.
- ID: latch Op/Func. Next state is EX for a decoded opcode. For an undecoded opcode, pulse IllegalOp and InstrDone and return to IF with no writes.
- EX: Aluc, AluSrcA, AluSrcB and ExtSe come from the latched Op/Func, using the single-cycle decode table (R-type funct table; ADDI/ADDIU/SLTI/SLTIU/ORI/ANDI/XORI; loads/stores use `ALUAdd` with `FromImmd`; branches use `ALUSub`). Next state:
  - Branch: PcWr=1 and PcSrc=`Branch` when taken, otherwise PcWr=0. Taken conditions: BEQ Zero; BNE !Zero; BGTZ !Sign&&!Zero; BGEZ !Sign; BLTZ Sign; BLEZ Sign||Zero. InstrDone=1, then IF.
  - J/JAL/JR: PcWr=1, PcSrc=`Jump`, InstrDone=1, then IF.
  - LW/LB/SW/SB: go to MEM.
  - All other instructions: go to WB.
- MEM: MemReq=1; memWr=1 for SW/SB. When MemRdy=1: a store pulses InstrDone and goes to IF; a load goes to WB. Otherwise stay in MEM.
- WB: regWr=1 for exactly one cycle. Wrback=`FromDM` for loads, else `FromALU`. RegDst=`FromRt` for I-type/loads, else `FromRd`. InstrDone=1, then IF.
- Timeout: the counter increments each cycle MemReq=1 && MemRdy=0, and clears on MemRdy or on leaving IF/MEM. When it reaches MEM_TIMEOUT: Fault=1 and state=HALT. HALT has all outputs at reset values except Fault=1, and exits only via rst_n. A MemRdy arriving in the same cycle as the counter reaching the limit wins (no Fault).
- Latency with MemRdy tied high: branch/jump 3 cycles, R/I-type ALU 4, store 4, load 5, illegal 2.
- Write enables (regWr, PcWr, IrWr, memWr) are never active outside the states listed above.

Test Plan:
- MemRdy=1, ADD (Op=000000, Func=100000) -> IF,ID,EX,WB; Aluc=`ALUAdd`, RegDst=`FromRd`, regWr=1 only in cycle 4, InstrDone in cycle 4.
- LW (Op=100011), MemRdy low 3 cycles in MEM -> MemReq held 4 cycles, memWr=0, Wrback=`FromDM`, RegDst=`FromRt`, regWr in cycle 8.
- BEQ (000100) Zero=1 then Zero=0 -> PcWr=1, PcSrc=`Branch` in EX; second case PcWr=0; both 3 cycles, regWr never 1.
- Op=111111 -> IllegalOp and InstrDone pulse in ID, no writes, next cycle IF with MemReq=1.
- MemRdy held 0 in IF -> Fault=1 after exactly 16 req cycles, HALT; MemRdy later high has no effect; rst_n low clears Fault.
- Assert rst_n=0 mid-MEM of SW (Op=101011) -> memWr, MemReq drop immediately (asynchronous); after release IDLE then IF.
